operand_fetch_stage: RTL and testbench

Decode-side reader of the MIPS register file and owner of the ID/EX pipeline register. Drives the file's `rs`/`rt` read addresses and takes its combinational read data. Substitutes newer values bypassed from MEM and WB, stalls on dependencies against the instruction currently in EX, and hands registered operands to EX over a valid/ready handshake.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/operand_fetch_stage_if.sv | 35 +++
 rtl/operand_fetch_stage_bypass_mux.sv | 20 ++
 rtl/operand_fetch_stage.sv | 66 ++++++
 tb/tb_operand_fetch_stage.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, register-zero constant and the ID/EX register layout.
package pipeline_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
        logic              is_load;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } idex_t;
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: ID-side and EX-side handshakes of the operand fetch stage.
interface operand_fetch_stage_if;
    import pipeline_pkg::*;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic [ADDR_W-1:0] id_rd;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_reg_write;
    logic              id_is_load;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc;
    logic              ex_flush;
    logic              ex_ready;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_is_load;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc;
    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_reg_write, id_is_load,
               id_imm, id_pc, ex_flush, ex_ready,
        input  id_ready, ex_valid, ex_op_a, ex_op_b, ex_rd, ex_reg_write, ex_is_load, ex_imm, ex_pc
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_reg_write, id_is_load,
               id_imm, id_pc, ex_flush, ex_ready,
        output id_ready, ex_valid, ex_op_a, ex_op_b, ex_rd, ex_reg_write, ex_is_load, ex_imm, ex_pc
    );
endinterface

// File: rtl/operand_fetch_stage_bypass_mux.sv
// bypass_mux: resolves one source operand; r0 reads zero, then MEM, WB, register file.
module bypass_mux
    import pipeline_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] op
);
    // addr is non-zero past the first test, so a destination of r0 can never match
    assign op = (addr == REG_ZERO)                  ? '0 :
                (mem_reg_write && mem_rd == addr)   ? mem_result :
                (wb_reg_write && wb_rd == addr)     ? wb_result :
                                                      rf_data;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads rs/rt, bypasses from MEM/WB, stalls on EX dependencies
// and owns the ID/EX register.
module operand_fetch_stage
    import pipeline_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    operand_fetch_stage_if.slave bus,
    output logic [ADDR_W-1:0]    rf_rs,
    output logic [ADDR_W-1:0]    rf_rt,
    input  logic [DATA_W-1:0]    rf_read_rs,
    input  logic [DATA_W-1:0]    rf_read_rt,
    input  logic                 mem_reg_write,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_result,
    input  logic                 wb_reg_write,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [DATA_W-1:0]    wb_result,
    output logic [15:0]          dep_stalls
);
    idex_t             r;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              hz;
    assign rf_rs = bus.id_rs;
    assign rf_rt = bus.id_rt;
    bypass_mux u_rs (
        .addr(bus.id_rs), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result), .rf_data(rf_read_rs), .op(op_a)
    );
    bypass_mux u_rt (
        .addr(bus.id_rt), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result), .rf_data(rf_read_rt), .op(op_b)
    );
    // The EX result is not available yet, so any dependency on it waits one cycle for MEM.
    assign hz = r.valid & r.reg_write & (r.rd != REG_ZERO) &
                ((bus.id_uses_rs & (bus.id_rs == r.rd)) | (bus.id_uses_rt & (bus.id_rt == r.rd)));
    assign bus.id_ready = ~bus.ex_flush & ~hz & (~r.valid | bus.ex_ready);
    always_ff @(posedge clk) begin
        if (reset) begin
            r          <= '0;
            dep_stalls <= '0;
        end else begin
            if (bus.ex_flush)
                r.valid <= 1'b0;
            else if (!r.valid || bus.ex_ready) begin
                if (bus.id_valid && bus.id_ready)
                    r <= '{valid: 1'b1, op_a: op_a, op_b: op_b, rd: bus.id_rd,
                           reg_write: bus.id_reg_write, is_load: bus.id_is_load,
                           imm: bus.id_imm, pc: bus.id_pc};
                else
                    r.valid <= 1'b0;
            end
            if (bus.id_valid && hz && !bus.ex_flush && dep_stalls != 16'hFFFF)
                dep_stalls <= dep_stalls + 16'd1;
        end
    end
    assign bus.ex_valid     = r.valid;
    assign bus.ex_op_a      = r.op_a;
    assign bus.ex_op_b      = r.op_b;
    assign bus.ex_rd        = r.rd;
    assign bus.ex_reg_write = r.reg_write;
    assign bus.ex_is_load   = r.is_load;
    assign bus.ex_imm       = r.imm;
    assign bus.ex_pc        = r.pc;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed vectors for bypassing, hazards, backpressure, flush and reset.
module tb_operand_fetch_stage;
    import pipeline_pkg::*;
    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rf_rs, rf_rt, mem_rd, wb_rd;
    logic [DATA_W-1:0] rf_read_rs, rf_read_rt, mem_result, wb_result;
    logic              mem_reg_write, wb_reg_write;
    logic [15:0]       dep_stalls;
    int                checks = 0;
    int                failures = 0;
    operand_fetch_stage_if bus();
    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .bus(bus), .rf_rs(rf_rs), .rf_rt(rf_rt),
        .rf_read_rs(rf_read_rs), .rf_read_rt(rf_read_rt),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .dep_stalls(dep_stalls)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic rw, input logic ld, input logic [31:0] pc);
        bus.id_valid = 1'b1;
        bus.id_rs = rs; bus.id_uses_rs = urs;
        bus.id_rt = rt; bus.id_uses_rt = urt;
        bus.id_rd = rd; bus.id_reg_write = rw; bus.id_is_load = ld;
        bus.id_pc = pc; bus.id_imm = pc + 32'h4;
    endtask
    task automatic bypass(input logic mw, input logic [4:0] md, input logic [31:0] mr,
                          input logic ww, input logic [4:0] wd, input logic [31:0] wr);
        mem_reg_write = mw; mem_rd = md; mem_result = mr;
        wb_reg_write = ww; wb_rd = wd; wb_result = wr;
    endtask
    initial begin
        reset = 1'b1;
        bus.ex_flush = 1'b0; bus.ex_ready = 1'b1;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        bus.id_valid = 1'b0;
        rf_read_rs = '0; rf_read_rt = '0;
        bypass(0, 0, 0, 0, 0, 0);
        step(); step();
        check("reset_valid", 32'(bus.ex_valid), 0);
        check("reset_op_a", bus.ex_op_a, 0);
        check("reset_pc", bus.ex_pc, 0);
        check("reset_stalls", 32'(dep_stalls), 0);
        reset = 1'b0;
        // WB bypass over stale register-file data
        instr(5, 1, 0, 0, 1, 1, 0, 32'h100);
        rf_read_rs = 32'h11;
        bypass(0, 0, 0, 1, 5, 32'h22);
        #1;
        check("rf_rs", 32'(rf_rs), 5);
        check("wb_ready", 32'(bus.id_ready), 1);
        step();
        check("wb_valid", 32'(bus.ex_valid), 1);
        check("wb_op_a", bus.ex_op_a, 32'h22);
        check("wb_rd", 32'(bus.ex_rd), 1);
        check("wb_imm", bus.ex_imm, 32'h104);
        // MEM beats WB on the same register
        instr(0, 0, 7, 1, 2, 1, 0, 32'h110);
        rf_read_rt = 32'h33;
        bypass(1, 7, 32'hAA, 1, 7, 32'hBB);
        step();
        check("prio_op_b", bus.ex_op_b, 32'hAA);
        check("prio_op_a", bus.ex_op_a, 0);
        // r0 always reads zero
        instr(0, 1, 0, 0, 0, 0, 0, 32'h120);
        rf_read_rs = 32'h123;
        bypass(1, 0, 32'hFF, 1, 0, 32'hEE);
        step();
        check("zero_op_a", bus.ex_op_a, 0);
        // load-use: one stall cycle, then MEM bypass
        bypass(0, 0, 0, 0, 0, 0);
        instr(0, 0, 0, 0, 3, 1, 1, 32'h130);
        step();
        check("load_in_ex", 32'(bus.ex_is_load), 1);
        instr(3, 1, 0, 0, 4, 1, 0, 32'h140);
        rf_read_rs = 32'h99;
        #1;
        check("lu_ready", 32'(bus.id_ready), 0);
        step();
        check("lu_bubble", 32'(bus.ex_valid), 0);
        check("lu_stalls", 32'(dep_stalls), 1);
        bypass(1, 3, 32'h55, 0, 0, 0);
        #1;
        check("lu_ready2", 32'(bus.id_ready), 1);
        step();
        check("lu_valid", 32'(bus.ex_valid), 1);
        check("lu_op_a", bus.ex_op_a, 32'h55);
        check("lu_rd", 32'(bus.ex_rd), 4);
        check("lu_stalls2", 32'(dep_stalls), 1);
        // backpressure holds the register
        bypass(0, 0, 0, 0, 0, 0);
        instr(1, 1, 0, 0, 5, 1, 0, 32'h200);
        bus.ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(bus.id_ready), 0);
            step();
            check("bp_valid", 32'(bus.ex_valid), 1);
            check("bp_rd", 32'(bus.ex_rd), 4);
            check("bp_pc", bus.ex_pc, 32'h140);
        end
        check("bp_stalls", 32'(dep_stalls), 1);
        bus.ex_ready = 1'b1;
        #1;
        check("bp_ready_back", 32'(bus.id_ready), 1);
        step();
        check("bp_rd_new", 32'(bus.ex_rd), 5);
        check("bp_pc_new", bus.ex_pc, 32'h200);
        // flush concurrent with a hazard
        instr(5, 1, 0, 0, 6, 1, 0, 32'h210);
        bus.ex_flush = 1'b1;
        #1;
        check("fl_ready", 32'(bus.id_ready), 0);
        step();
        bus.ex_flush = 1'b0;
        check("fl_valid", 32'(bus.ex_valid), 0);
        check("fl_stalls", 32'(dep_stalls), 1);
        // reset in the middle of a stall
        instr(0, 0, 0, 0, 6, 1, 0, 32'h300);
        step();
        instr(0, 0, 6, 1, 7, 1, 0, 32'h310);
        bus.ex_ready = 1'b0;
        step();
        check("rs_stalls", 32'(dep_stalls), 2);
        check("rs_held", 32'(bus.ex_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.id_valid = 1'b0;
        check("rst_valid", 32'(bus.ex_valid), 0);
        check("rst_stalls", 32'(dep_stalls), 0);
        check("rst_rd", 32'(bus.ex_rd), 0);
        check("rst_pc", bus.ex_pc, 0);
        check("rst_rw", 32'(bus.ex_reg_write), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
